// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, engine states and burst helper functions
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] BURST_SINGLE = 3'd0;
   localparam logic [2:0] BURST_INCR   = 3'd1;
   localparam logic [2:0] BURST_WRAP4  = 3'd2;
   localparam logic [2:0] BURST_INCR4  = 3'd3;
   localparam logic [2:0] BURST_WRAP8  = 3'd4;
   localparam logic [2:0] BURST_INCR8  = 3'd5;
   localparam logic [2:0] BURST_WRAP16 = 3'd6;
   localparam logic [2:0] BURST_INCR16 = 3'd7;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST} state_t;
   function automatic logic [4:0] beats_of(input logic [2:0] burst, input logic [4:0] len);
      return burst == BURST_SINGLE ? 5'd1 :
             burst == BURST_INCR   ? (len == 5'd0 ? 5'd1 : len > 5'd16 ? 5'd16 : len) :
             burst[2:1] == 2'b01   ? 5'd4 :
             burst[2:1] == 2'b10   ? 5'd8 : 5'd16;
   endfunction
   // incrementing bursts get an all-ones mask so the wrap formula degenerates to a plain add
   function automatic logic [31:0] wrap_mask(input logic [2:0] burst, input logic [2:0] size);
      return (burst[0] || burst == BURST_SINGLE) ? '1 : (32'(beats_of(burst, 5'd0)) << size) - 32'd1;
   endfunction
endpackage

// File: rtl/ahb_master_burst_engine_if.sv
// ahb_master_burst_engine_if: command port plus AHB-Lite master bus of the burst engine
interface ahb_master_burst_engine_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_size;
   logic [2:0]        cmd_burst;
   logic [4:0]        cmd_len;
   logic              cmd_write;
   logic              HREADY;
   logic              HRESP;
   logic [DATA_W-1:0] HRDATA;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [DATA_W-1:0] HWDATA;
   logic              done;
   logic              error;
   logic [DATA_W-1:0] dbg_data;
   modport master (
      input  cmd_valid, cmd_addr, cmd_size, cmd_burst, cmd_len, cmd_write, HREADY, HRESP, HRDATA,
      output cmd_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, done, error, dbg_data
   );
   modport slave (
      output cmd_valid, cmd_addr, cmd_size, cmd_burst, cmd_len, cmd_write, HREADY, HRESP, HRDATA,
      input  cmd_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, done, error, dbg_data
   );
endinterface

// File: rtl/ahb_addr_step.sv
// ahb_addr_step: next beat address for SINGLE, INCR* and WRAP* bursts
module ahb_addr_step import ahb_pkg::*; #(
   parameter int ADDR_W = 8
) (
   input  logic [2:0]        burst,
   input  logic [2:0]        size,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_nxt
);
   logic [ADDR_W-1:0] mask, inc;
   // keep the bits above the wrap boundary and advance only the bits inside it
   always_comb begin
      mask = ADDR_W'(wrap_mask(burst, size));
      inc = ADDR_W'(32'd1 << size);
      addr_nxt = burst == BURST_SINGLE ? addr : (addr & ~mask) | ((addr + inc) & mask);
   end
endmodule

// File: rtl/ahb_master_burst_engine.sv
// ahb_master_burst_engine: AHB-Lite burst master moving words between a local buffer and the bus
module ahb_master_burst_engine import ahb_pkg::*; #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int INIT_MULT = 2
) (
   input logic HCLK,
   input logic rst,
   ahb_master_burst_engine_if.master bus
);
   localparam int LANE_W = $clog2(DATA_W / 8);
   localparam int IDX_W  = ADDR_W - LANE_W;
   localparam int DEPTH  = 1 << IDX_W;
   if (ADDR_W > 10 || (DATA_W != 32 && DATA_W != 64)) begin : g_param_check
      $error("ahb_master_burst_engine: ADDR_W must be <= 10 and DATA_W 32 or 64");
   end
   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] haddr, step;
   logic [IDX_W-1:0]  dp_idx;
   logic [1:0]        htrans;
   logic [2:0]        hsize, hburst;
   logic [4:0]        cnt;
   logic              hwrite, dp_write, dp_valid, done_q, error_q;
   logic              accept, illegal, take, fin, abort;
   ahb_addr_step #(.ADDR_W(ADDR_W)) u_step (.burst(hburst), .size(hsize), .addr(haddr), .addr_nxt(step));
   // transfer strobes and next state; an errored data phase pre-empts everything else
   always_comb begin
      accept = state == ST_IDLE && bus.cmd_valid;
      illegal = bus.cmd_size > 3'(LANE_W) || |(bus.cmd_addr & ADDR_W'((32'd1 << bus.cmd_size) - 32'd1));
      abort = dp_valid && bus.HRESP && bus.HREADY;
      take = state == ST_ADDR && bus.HREADY && !(dp_valid && bus.HRESP);
      fin = state == ST_LAST && bus.HREADY && !bus.HRESP;
      state_nxt = abort || fin ? ST_IDLE : accept && !illegal ? ST_ADDR : take && cnt == 5'd0 ? ST_LAST : state;
   end
   // state register
   always_ff @(posedge HCLK) state <= rst ? ST_IDLE : state_nxt;
   // address/data phase pipeline, beat counter and buffer
   always_ff @(posedge HCLK) begin
      if (rst) begin
         haddr <= '0;
         htrans <= HTRANS_IDLE;
         hwrite <= 1'b0;
         hsize <= 3'd0;
         hburst <= 3'd0;
         cnt <= 5'd0;
         dp_idx <= '0;
         dp_write <= 1'b0;
         dp_valid <= 1'b0;
         done_q <= 1'b0;
         error_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i * INIT_MULT);
      end else begin
         done_q <= fin;
         error_q <= abort || (accept && illegal);
         if (accept && !illegal) begin
            haddr <= bus.cmd_addr;
            htrans <= HTRANS_NONSEQ;
            hwrite <= bus.cmd_write;
            hsize <= bus.cmd_size;
            hburst <= bus.cmd_burst;
            cnt <= beats_of(bus.cmd_burst, bus.cmd_len) - 5'd1;
         end
         if (take) begin
            dp_idx <= haddr[ADDR_W-1:LANE_W];
            dp_write <= hwrite;
            dp_valid <= 1'b1;
            htrans <= cnt == 5'd0 ? HTRANS_IDLE : HTRANS_SEQ;
            haddr <= cnt == 5'd0 ? haddr : step;
            cnt <= cnt == 5'd0 ? cnt : cnt - 5'd1;
         end
         if (fin || abort) begin
            dp_valid <= 1'b0;
            htrans <= HTRANS_IDLE;
         end
         if (dp_valid && !dp_write && bus.HREADY && !bus.HRESP) mem[dp_idx] <= bus.HRDATA;
      end
   end
   assign bus.cmd_ready = state == ST_IDLE;
   assign bus.HADDR = haddr;
   assign bus.HTRANS = dp_valid && bus.HRESP ? HTRANS_IDLE : htrans;
   assign bus.HWRITE = hwrite;
   assign bus.HSIZE = hsize;
   assign bus.HBURST = hburst;
   assign bus.HWDATA = mem[dp_idx];
   assign bus.done = done_q;
   assign bus.error = error_q;
   assign bus.dbg_data = mem[haddr[ADDR_W-1:LANE_W]];
endmodule

// File: tb/tb_ahb_master_burst_engine.sv
// tb_ahb_master_burst_engine: directed and randomized bursts against a transaction-level bus model
module tb_ahb_master_burst_engine;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MULT = 2;
   localparam int DEPTH = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] model [DEPTH];

   ahb_master_burst_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   ahb_master_burst_engine #(.ADDR_W(AW), .DATA_W(DW), .INIT_MULT(MULT)) dut (
      .HCLK(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'(i * MULT);
   endtask

   // wb/wn: stall wn cycles while beat wb is in its address phase; eb: beat that gets an error
   // response; ra: cycle at which reset is asserted; rw: random HREADY stalls
   task automatic run_cmd(input logic [7:0] a, input logic [2:0] sz, input logic [2:0] bu,
                          input logic [4:0] ln, input logic wr, input int wb, input int wn,
                          input int eb, input int ra, input bit rw);
      int n, bytes, total, ap, dp, wleft, cyc;
      bit ephase, legal, wrap;
      logic [7:0] adr [16];
      logic [7:0] base;
      logic [31:0] rd;
      logic hrdy, hrsp;
      bytes = 1 << sz;
      legal = sz <= 3'd2 && (int'(a) % bytes) == 0;
      n = bu == 3'd0 ? 1 : bu == 3'd1 ? (ln == 5'd0 ? 1 : ln > 5'd16 ? 16 : int'(ln)) :
          bu < 3'd4 ? 4 : bu < 3'd6 ? 8 : 16;
      wrap = bu inside {3'd2, 3'd4, 3'd6};
      total = n * bytes;
      base = 8'(int'(a) - int'(a) % total);
      for (int k = 0; k < n; k++)
         adr[k] = bu == 3'd0 ? a :
                  wrap ? 8'(int'(base) + (int'(a) - int'(base) + k * bytes) % total) :
                  8'(int'(a) + k * bytes);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr = a;
      bus.cmd_size = sz;
      bus.cmd_burst = bu;
      bus.cmd_len = ln;
      bus.cmd_write = wr;
      #1;
      chk("cmd_ready_idle", 64'(bus.cmd_ready), 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr = 8'($urandom);
      bus.cmd_size = 3'($urandom);
      bus.cmd_burst = 3'($urandom);
      bus.cmd_len = 5'($urandom);
      bus.cmd_write = 1'($urandom);
      if (!legal) begin
         chk("illegal_error", 64'(bus.error), 1);
         chk("illegal_htrans", 64'(bus.HTRANS), 0);
         chk("illegal_ready", 64'(bus.cmd_ready), 1);
         @(posedge clk);
         #1;
         chk("illegal_error_pulse", 64'(bus.error), 0);
         chk("illegal_htrans2", 64'(bus.HTRANS), 0);
         return;
      end
      ap = 0;
      dp = -1;
      wleft = wn;
      ephase = 1'b0;
      cyc = 0;
      forever begin
         rd = $urandom;
         hrsp = 1'b0;
         if (dp >= 0 && dp == eb) begin
            hrsp = 1'b1;
            hrdy = ephase;
         end else if (ap == wb && wleft > 0) begin
            hrdy = 1'b0;
            wleft--;
         end else hrdy = rw ? ($urandom_range(3) != 0) : 1'b1;
         bus.HREADY = hrdy;
         bus.HRESP = hrsp;
         bus.HRDATA = rd;
         bus.cmd_valid = 1'($urandom_range(1));
         #1;
         chk("htrans", 64'(bus.HTRANS), (dp >= 0 && hrsp) || ap >= n ? 64'h0 : ap == 0 ? 64'h2 : 64'h3);
         if (ap < n) begin
            chk("haddr", 64'(bus.HADDR), 64'(adr[ap]));
            chk("hwrite", 64'(bus.HWRITE), 64'(wr));
            chk("dbg_data", 64'(bus.dbg_data), 64'(model[adr[ap] >> 2]));
         end
         chk("hsize", 64'(bus.HSIZE), 64'(sz));
         chk("hburst", 64'(bus.HBURST), 64'(bu));
         if (dp >= 0 && wr) chk("hwdata", 64'(bus.HWDATA), 64'(model[adr[dp] >> 2]));
         chk("done_busy", 64'(bus.done), 0);
         chk("error_busy", 64'(bus.error), 0);
         chk("ready_busy", 64'(bus.cmd_ready), 0);
         if (cyc == ra) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_htrans", 64'(bus.HTRANS), 0);
            chk("rst_haddr", 64'(bus.HADDR), 0);
            chk("rst_ready", 64'(bus.cmd_ready), 1);
            chk("rst_done", 64'(bus.done), 0);
            rst = 1'b0;
            bus.cmd_valid = 1'b0;
            bus.HREADY = 1'b1;
            bus.HRESP = 1'b0;
            model_reset();
            return;
         end
         cyc++;
         if (cyc > 300) begin
            chk("timeout_cycles", 64'(cyc), 0);
            return;
         end
         @(posedge clk);
         #1;
         bus.cmd_valid = 1'b0;
         bus.HREADY = 1'b1;
         bus.HRESP = 1'b0;
         if (hrsp && !hrdy) ephase = 1'b1;
         else if (hrdy) begin
            if (hrsp) begin
               chk("abort_error", 64'(bus.error), 1);
               chk("abort_ready", 64'(bus.cmd_ready), 1);
               chk("abort_done", 64'(bus.done), 0);
               chk("abort_htrans", 64'(bus.HTRANS), 0);
               break;
            end
            if (dp >= 0 && !wr) model[adr[dp] >> 2] = rd;
            if (dp == n - 1) begin
               chk("final_done", 64'(bus.done), 1);
               chk("final_ready", 64'(bus.cmd_ready), 1);
               chk("final_error", 64'(bus.error), 0);
               chk("final_htrans", 64'(bus.HTRANS), 0);
               break;
            end
            if (ap < n) begin
               dp = ap;
               ap++;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("done_pulse", 64'(bus.done), 0);
      chk("error_pulse", 64'(bus.error), 0);
   endtask

   initial begin
      logic [7:0] a;
      logic [2:0] sz, bu;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr = '0;
      bus.cmd_size = '0;
      bus.cmd_burst = '0;
      bus.cmd_len = '0;
      bus.cmd_write = 1'b0;
      bus.HREADY = 1'b1;
      bus.HRESP = 1'b0;
      bus.HRDATA = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_htrans", 64'(bus.HTRANS), 0);
      chk("reset_haddr", 64'(bus.HADDR), 0);
      chk("reset_hwrite", 64'(bus.HWRITE), 0);
      chk("reset_hsize", 64'(bus.HSIZE), 0);
      chk("reset_hburst", 64'(bus.HBURST), 0);
      chk("reset_done", 64'(bus.done), 0);
      chk("reset_error", 64'(bus.error), 0);
      chk("reset_ready", 64'(bus.cmd_ready), 1);
      chk("reset_dbg", 64'(bus.dbg_data), 0);
      rst = 1'b0;
      model_reset();
      run_cmd(8'h10, 3'd2, 3'd3, 5'd0, 1'b1, -1, 0, -1, -1, 1'b0);
      run_cmd(8'h38, 3'd2, 3'd2, 5'd0, 1'b0, -1, 0, -1, -1, 1'b0);
      run_cmd(8'h38, 3'd2, 3'd0, 5'd0, 1'b1, -1, 0, -1, -1, 1'b0);
      run_cmd(8'h40, 3'd2, 3'd5, 5'd0, 1'b1, 2, 3, -1, -1, 1'b0);
      run_cmd(8'h80, 3'd2, 3'd7, 5'd0, 1'b0, -1, 0, 1, -1, 1'b0);
      run_cmd(8'h84, 3'd2, 3'd0, 5'd0, 1'b1, -1, 0, -1, -1, 1'b0);
      run_cmd(8'h02, 3'd2, 3'd1, 5'd4, 1'b1, -1, 0, -1, -1, 1'b0);
      run_cmd(8'h20, 3'd2, 3'd1, 5'd0, 1'b0, -1, 0, -1, -1, 1'b0);
      run_cmd(8'hF8, 3'd1, 3'd6, 5'd0, 1'b0, -1, 0, -1, -1, 1'b1);
      run_cmd(8'hF0, 3'd2, 3'd1, 5'd31, 1'b1, -1, 0, -1, -1, 1'b0);
      for (int t = 0; t < 40; t++) begin
         sz = 3'($urandom_range(2));
         a = 8'($urandom) & ~8'((1 << sz) - 1);
         if ($urandom_range(7) == 0) begin
            sz = 3'd2;
            a = a | 8'd1;
         end else if ($urandom_range(15) == 0) sz = 3'd3;
         bu = 3'($urandom);
         run_cmd(a, sz, bu, 5'($urandom), 1'($urandom), $urandom_range(15), $urandom_range(3),
                 $urandom_range(4) == 0 ? $urandom_range(15) : -1, -1, 1'b1);
      end
      run_cmd(8'h14, 3'd2, 3'd0, 5'd0, 1'b0, -1, 0, -1, -1, 1'b0);
      run_cmd(8'h00, 3'd2, 3'd5, 5'd0, 1'b1, -1, 0, -1, 3, 1'b0);
      run_cmd(8'h14, 3'd2, 3'd0, 5'd0, 1'b1, -1, 0, -1, -1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
